regfile: RTL

REGFILE -- requirements
Module: regfile

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_bypass.sv | 37 +++
 rtl/regfile.sv | 132 +++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register file: default widths, the PC reset
// value and the clear/ready state encoding.
package regfile_pkg;

   localparam int          DEF_DAT_WIDTH = 64;
   localparam logic [63:0] DEF_PC_RESET  = 64'h0000_8000_0000_0000;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_e;

endpackage : regfile_pkg

// File: rtl/regfile_bypass.sv
// One read port's next-value selection: range and zero-register masking,
// then write-first forwarding of the array write in flight.
module regfile_bypass
   import regfile_pkg::*;
#(
   parameter int DAT_WIDTH = DEF_DAT_WIDTH,
   parameter int NUM_REGS  = 32,
   parameter int ID_W      = $clog2(NUM_REGS),
   parameter bit ZERO_REG  = 1'b1
) (
   input  logic [ID_W-1:0]      rd_id,
   input  logic                 wr_en,
   input  logic [ID_W-1:0]      wr_id,
   input  logic [DAT_WIDTH-1:0] wr_dat,
   input  logic [DAT_WIDTH-1:0] stored,
   output logic [DAT_WIDTH-1:0] dat
);

   localparam logic [ID_W:0] NUM_REGS_W = (ID_W+1)'(NUM_REGS);

   logic in_range;
   logic is_zero;

   assign in_range = ({1'b0, rd_id} < NUM_REGS_W);
   assign is_zero  = ZERO_REG && (rd_id == '0);

   // NOTE: the default assignment first keeps this block free of inferred latches.
   always_comb begin
      dat = stored;
      if (!in_range || is_zero) begin
         dat = '0;
      end else if (wr_en && (wr_id == rd_id)) begin
         dat = wr_dat;
      end
   end

endmodule : regfile_bypass

// File: rtl/regfile.sv
// Register file with a dedicated PC register, a self-clearing sequence after
// reset, write-first registered read ports and PC auto-increment.
module regfile
   import regfile_pkg::*;
#(
   parameter int                   DAT_WIDTH = DEF_DAT_WIDTH,
   parameter int                   NUM_REGS  = 32,
   parameter int                   RD_PORTS  = 2,
   parameter int                   PC_ID     = NUM_REGS - 1,
   parameter logic [DAT_WIDTH-1:0] PC_RESET  = DAT_WIDTH'(DEF_PC_RESET),
   parameter bit                   ZERO_REG  = 1'b1,
   localparam int                  ID_W      = $clog2(NUM_REGS)
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          we_i,
   input  logic [ID_W-1:0]               wr_id_i,
   input  logic [DAT_WIDTH-1:0]          wr_dat_i,
   input  logic [RD_PORTS*ID_W-1:0]      rd_id_i,
   output logic [RD_PORTS*DAT_WIDTH-1:0] rd_dat_o,
   input  logic                          pc_inc_i,
   output logic [DAT_WIDTH-1:0]          pc_o,
   output logic                          busy_o
);

   localparam logic [ID_W-1:0]      PC_IDX     = ID_W'(PC_ID);
   localparam logic [ID_W-1:0]      LAST_IDX   = ID_W'(NUM_REGS - 1);
   localparam logic [ID_W:0]        NUM_REGS_W = (ID_W+1)'(NUM_REGS);
   localparam logic [DAT_WIDTH-1:0] PC_STEP    = DAT_WIDTH'(DAT_WIDTH / 8);

   state_e                 state_q, state_d;
   logic [ID_W-1:0]        cnt_q, cnt_d;
   logic [DAT_WIDTH-1:0]   pc_q, pc_d;
   logic [DAT_WIDTH-1:0]   regs [NUM_REGS];

   logic                   wr_ok;
   logic                   arr_we;
   logic [ID_W-1:0]        arr_id;
   logic [DAT_WIDTH-1:0]   arr_dat;

   assign wr_ok = we_i && ({1'b0, wr_id_i} < NUM_REGS_W) && !(ZERO_REG && (wr_id_i == '0));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pc_q    <= pc_d;
      end
   end

   // The PC lives outside the array so an increment can coexist with a write elsewhere.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pc_d    = pc_q;
      arr_we  = 1'b0;
      arr_id  = cnt_q;
      arr_dat = '0;
      case (state_q)
         CLEAR: begin
            arr_we = (cnt_q != PC_IDX);
            if (cnt_q == PC_IDX) pc_d = PC_RESET;
            if (cnt_q == LAST_IDX) state_d = READY;
            else                   cnt_d   = cnt_q + 1'b1;
         end
         READY: begin
            if (wr_ok && (wr_id_i == PC_IDX)) begin
               pc_d = wr_dat_i;
            end else begin
               if (wr_ok) begin
                  arr_we  = 1'b1;
                  arr_id  = wr_id_i;
                  arr_dat = wr_dat_i;
               end
               if (pc_inc_i) pc_d = pc_q + PC_STEP;
            end
         end
         default: state_d = CLEAR;
      endcase
   end

   // NOTE: the storage array has no reset; the clear sequence initialises it instead.
   always_ff @(posedge clk_i) begin
      if (arr_we && !rst_i) regs[arr_id] <= arr_dat;
   end

   for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
      logic [ID_W-1:0]      id;
      logic [DAT_WIDTH-1:0] stored;
      logic [DAT_WIDTH-1:0] nxt;
      logic [DAT_WIDTH-1:0] dat_q;

      assign id = rd_id_i[k*ID_W +: ID_W];

      // PC reads take the post-edge PC value, which gives write-first behaviour for free.
      always_comb begin
         stored = '0;
         if (id == PC_IDX)                        stored = pc_d;
         else if ({1'b0, id} < NUM_REGS_W)        stored = regs[id];
      end

      regfile_bypass #(
         .DAT_WIDTH (DAT_WIDTH),
         .NUM_REGS  (NUM_REGS),
         .ID_W      (ID_W),
         .ZERO_REG  (ZERO_REG)
      ) u_bypass (
         .rd_id  (id),
         .wr_en  (arr_we),
         .wr_id  (arr_id),
         .wr_dat (arr_dat),
         .stored (stored),
         .dat    (nxt)
      );

      always_ff @(posedge clk_i) begin
         if (rst_i || (state_q != READY)) dat_q <= '0;
         else                             dat_q <= nxt;
      end

      assign rd_dat_o[k*DAT_WIDTH +: DAT_WIDTH] = dat_q;
   end

   assign pc_o   = pc_q;
   assign busy_o = (state_q == CLEAR);

endmodule : regfile
